// File: rtl/rs_issue_scheduler_if.sv
// Reservation-station issue scheduler bus.
// Groups the station-facing signals (allocation, busy/ready vectors, selection
// and payload mux) and the ALU-facing valid/ready output stage.
//   master : the scheduler (drives sel_*, alu_valid, alu_* payload)
//   slave  : the station/ALU side (drives everything else)
interface rs_issue_scheduler_if #(
   parameter int unsigned RS_SIZE = 16,
   parameter int unsigned IDX_W   = 4
);
   logic               rdy;
   logic               clear;
   logic               alloc_en;
   logic [IDX_W-1:0]   alloc_idx;
   logic [RS_SIZE-1:0] entry_busy;
   logic [RS_SIZE-1:0] entry_ready;
   logic               sel_valid;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_take;
   logic [5:0]         in_opcode;
   logic [3:0]         in_rob_id;
   logic [31:0]        in_val1;
   logic [31:0]        in_val2;
   logic [31:0]        in_imm;
   logic [31:0]        in_pc;
   logic               alu_valid;
   logic               alu_ready;
   logic [5:0]         alu_opcode;
   logic [3:0]         alu_rob_id;
   logic [31:0]        alu_val1;
   logic [31:0]        alu_val2;
   logic [31:0]        alu_imm;
   logic [31:0]        alu_pc;

   modport master (
      input  rdy, clear, alloc_en, alloc_idx, entry_busy, entry_ready,
      input  in_opcode, in_rob_id, in_val1, in_val2, in_imm, in_pc, alu_ready,
      output sel_valid, sel_idx, sel_take,
      output alu_valid, alu_opcode, alu_rob_id, alu_val1, alu_val2, alu_imm, alu_pc
   );

   modport slave (
      output rdy, clear, alloc_en, alloc_idx, entry_busy, entry_ready,
      output in_opcode, in_rob_id, in_val1, in_val2, in_imm, in_pc, alu_ready,
      input  sel_valid, sel_idx, sel_take,
      input  alu_valid, alu_opcode, alu_rob_id, alu_val1, alu_val2, alu_imm, alu_pc
   );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Oldest-first issue scheduler for the reservation station.
// An age matrix (older_q[i][j] = entry i allocated before entry j) picks the
// oldest busy entry whose operands are ready; its payload is latched into a
// one-deep registered ALU stage with a valid/ready handshake.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   bus_io : scheduler side of rs_issue_scheduler_if (station + ALU signals)
module rs_issue_scheduler #(
   parameter int unsigned RS_SIZE = 16,
   parameter int unsigned IDX_W   = 4
) (
   input logic                  clk,
   input logic                  rst,
   rs_issue_scheduler_if.master bus_io
);

   logic [RS_SIZE-1:0] older_q [RS_SIZE];
   logic [RS_SIZE-1:0] older_d [RS_SIZE];

   logic        alu_valid_q, alu_valid_d;
   logic [5:0]  opcode_q, opcode_d;
   logic [3:0]  rob_id_q, rob_id_d;
   logic [31:0] val1_q, val1_d;
   logic [31:0] val2_q, val2_d;
   logic [31:0] imm_q, imm_d;
   logic [31:0] pc_q, pc_d;

   logic [RS_SIZE-1:0] cand;
   logic [RS_SIZE-1:0] blocked;
   logic [RS_SIZE-1:0] take_mask;
   logic               sel_valid;
   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic               acc;

   // Selection: a candidate is blocked if any older entry is also a candidate.
   always_comb begin
      cand      = bus_io.entry_busy & bus_io.entry_ready;
      blocked   = '0;
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
         for (int j = 0; j < RS_SIZE; j++) begin
            blocked[i] = blocked[i] | (cand[j] & older_q[j][i]);
         end
      end
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!sel_found && cand[i] && !blocked[i]) begin
            sel_idx   = IDX_W'(i);
            sel_found = 1'b1;
         end
      end
      sel_valid = |cand;
      acc       = bus_io.rdy & ~bus_io.clear & sel_valid &
                  (~alu_valid_q | bus_io.alu_ready);
      take_mask = '0;
      if (acc) begin
         take_mask[sel_idx] = 1'b1;
      end
   end

   // Age matrix update. The entry taken at this edge is not counted as older
   // than the new one; stale bits of freed entries are overwritten on realloc.
   always_comb begin
      older_d = older_q;
      if (bus_io.rdy) begin
         if (bus_io.clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
               older_d[i] = '0;
            end
         end else if (bus_io.alloc_en) begin
            older_d[bus_io.alloc_idx] = '0;
            for (int j = 0; j < RS_SIZE; j++) begin
               older_d[j][bus_io.alloc_idx] = bus_io.entry_busy[j] & ~take_mask[j];
            end
            older_d[bus_io.alloc_idx][bus_io.alloc_idx] = 1'b0;
         end
      end
   end

   // Output stage: clear wins, then accept, then drain.
   always_comb begin
      alu_valid_d = alu_valid_q;
      opcode_d    = opcode_q;
      rob_id_d    = rob_id_q;
      val1_d      = val1_q;
      val2_d      = val2_q;
      imm_d       = imm_q;
      pc_d        = pc_q;
      if (bus_io.rdy) begin
         if (bus_io.clear) begin
            alu_valid_d = 1'b0;
         end else if (acc) begin
            alu_valid_d = 1'b1;
            opcode_d    = bus_io.in_opcode;
            rob_id_d    = bus_io.in_rob_id;
            val1_d      = bus_io.in_val1;
            val2_d      = bus_io.in_val2;
            imm_d       = bus_io.in_imm;
            pc_d        = bus_io.in_pc;
         end else if (alu_valid_q && bus_io.alu_ready) begin
            alu_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         older_q     <= '{default: '0};
         alu_valid_q <= 1'b0;
         opcode_q    <= '0;
         rob_id_q    <= '0;
         val1_q      <= '0;
         val2_q      <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
      end else begin
         older_q     <= older_d;
         alu_valid_q <= alu_valid_d;
         opcode_q    <= opcode_d;
         rob_id_q    <= rob_id_d;
         val1_q      <= val1_d;
         val2_q      <= val2_d;
         imm_q       <= imm_d;
         pc_q        <= pc_d;
      end
   end

   assign bus_io.sel_valid  = sel_valid;
   assign bus_io.sel_idx    = sel_idx;
   assign bus_io.sel_take   = acc;
   assign bus_io.alu_valid  = alu_valid_q;
   assign bus_io.alu_opcode = opcode_q;
   assign bus_io.alu_rob_id = rob_id_q;
   assign bus_io.alu_val1   = val1_q;
   assign bus_io.alu_val2   = val2_q;
   assign bus_io.alu_imm    = imm_q;
   assign bus_io.alu_pc     = pc_q;

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Issue scheduler for the 16-entry reservation station: picks the oldest entry whose operands are both ready.
- Pulls the selected entry's payload out of the station and presents it to the ALU through a one-deep registered output stage with a valid/ready handshake.
- Tracks allocation order with an age matrix, so selection is strictly oldest-first and starvation-free.

Parameters:
RS_SIZE, 16, number of reservation-station entries
IDX_W, 4, entry index width (log2 RS_SIZE)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global enable; low = hold all state, no take
clear  in  1  pipeline flush (mispredict)
alloc_en  in  1  station allocates an entry this cycle
alloc_idx  in  IDX_W  index being allocated
entry_busy  in  RS_SIZE  per-entry busy bits from station
entry_ready  in  RS_SIZE  per-entry both-operands-ready bits (Ri&Rj)
sel_valid  out  1  a ready entry is selected (combinational)
sel_idx  out  IDX_W  selected entry index (combinational)
sel_take  out  1  station must free entry sel_idx at this edge
in_opcode  in  6  payload of entry sel_idx, muxed by station
in_rob_id  in  4  payload: ROB tag
in_val1  in  32  payload: operand 1
in_val2  in  32  payload: operand 2
in_imm  in  32  payload: immediate
in_pc  in  32  payload: pc
alu_valid  out  1  output stage holds an instruction
alu_ready  in  1  ALU accepts this cycle
alu_opcode  out  6  registered payload
alu_rob_id  out  4  registered payload
alu_val1  out  32  registered payload
alu_val2  out  32  registered payload
alu_imm  out  32  registered payload
alu_pc  out  32  registered payload

Behaviour:
- Reset (rst low, async): age matrix all 0, alu_valid=0, all alu_* payload outputs 0.
- Age matrix: older[i][j]=1 means entry i was allocated before entry j.
  - On alloc_en && rdy && !clear with alloc_idx=k: older[k][*]<=0, older[*][k]<=entry_busy[*] (bits for entries freed by the same-edge take ignored), older[k][k]=0.
- Candidate c[i] = entry_busy[i] & entry_ready[i].
- Selection (combinational): sel_idx = the i with c[i]=1 and no j with c[j]&older[j][i]. sel_valid = |c. When sel_valid=0, sel_idx=0.
- Accept condition: acc = rdy & !clear & sel_valid & (!alu_valid | alu_ready). sel_take = acc, a combinational pulse; the station frees the entry at the same edge.
- Output stage at posedge, rdy high, clear low:
  - If acc: alu_valid<=1 and latch all in_* into alu_*.
  - Else if alu_valid && alu_ready: alu_valid<=0, payload held.
- Latency: an entry ready (registered in the station) in cycle N is seen by the ALU as alu_valid in cycle N+1.
- Throughput: 1 issue/cycle while alu_ready is held high.
- Back-pressure: if alu_valid=1 and alu_ready=0, payload and alu_valid hold stable, sel_take=0, and station entries are untouched.
- rdy low: no state change, sel_take=0, outputs hold.
- clear (sync, priority over everything except rst): alu_valid<=0, age matrix cleared, sel_take=0. An alloc in the same cycle is ignored, because the station also flushes.
- Simultaneous alloc of entry k and take of entry m (k≠m) both apply. alloc_idx never equals a busy index; behaviour for that case is undefined.
- Freed entries need no matrix clean-up: stale bits are masked by entry_busy at the next allocation.
- No entry ready and output empty: alu_valid falls to 0 after the current payload is accepted.

Test Plan:
- Reset mid-issue: drive rst low while alu_valid=1 -> alu_valid=0 and alu_* =0 immediately, without waiting for clk.
- Oldest-first: allocate entries 5, then 2, then 9; make all three ready in the same cycle; alu_ready=1 -> issue order rob_ids of 5, 2, 9 on consecutive cycles, sel_take pulses with sel_idx 5, 2, 9.
- Back-pressure: entry 3 issued, alu_ready=0 for 3 cycles, entry 7 ready -> alu_* stable with entry 3 payload, sel_take=0; on alu_ready=1 entry 7 is taken the same cycle and appears next cycle.
- Out-of-order readiness: allocate 1 then 4; only 4 ready -> 4 issues first; 1 issues when its ready bit rises.
- Flush: alu_valid=1, entries 0 and 6 ready, clear=1 for one cycle -> alu_valid=0 next cycle, no sel_take that cycle; after refill, a new alloc of 6 then 0 issues in order 6, 0.
- rdy stall: rdy=0 with entry 2 ready and alu_ready=1 -> no take, outputs frozen; rdy=1 -> entry 2 issues next cycle.
